// File: rtl/ntt_address_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared constants and FSM state type for the 1024-point
//                radix-2 NTT address sequencer and its memory map.
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int LOGN   = 10;
  localparam int N      = 1 << LOGN;
  localparam int BANKS  = 8;
  localparam int ROWS   = N / BANKS;
  localparam int STAGES = LOGN;
  localparam int BEATS  = 128;

  // Sequencer states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_address_generator_lane_addr.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_lane_addr
//  Description : Combinational butterfly address map for one lane. Maps
//                butterfly index k and stage s to the top/bottom coefficient
//                addresses and the twiddle exponent.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_lane_addr
  import ntt_pkg::*;
(
  input  logic [LOGN-2:0] k,
  input  logic [3:0]      s,
  output logic [LOGN-1:0] top,
  output logic [LOGN-1:0] bottom,
  output logic [LOGN-2:0] twiddle
);

  logic [LOGN-1:0] w_k_ext;
  logic [LOGN-1:0] w_span;
  logic [LOGN-1:0] w_j;
  logic [LOGN-1:0] w_blk;

  // Split k into block and in-block offset, then re-insert a zero bit at s
  always_comb begin
    w_k_ext = {1'b0, k};
    w_span  = LOGN'(1) << s;
    w_j     = w_k_ext & (w_span - LOGN'(1));
    w_blk   = w_k_ext >> s;
    top     = (w_blk << (s + 4'd1)) | w_j;
    bottom  = top + w_span;
    twiddle = w_j[LOGN-2:0] << (4'(LOGN - 1) - s);
  end

endmodule
`default_nettype wire

// File: rtl/ntt_address_generator.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_address_generator
//  Description : Stage/butterfly address sequencer for the 1024-point NTT.
//                Issues eight coefficient addresses and four twiddle indices
//                per beat over all stages, with valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_address_generator #(
  parameter int LOGN  = 10,
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inverse,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGN-1:0] old_address_0,
  output logic [LOGN-1:0] old_address_1,
  output logic [LOGN-1:0] old_address_2,
  output logic [LOGN-1:0] old_address_3,
  output logic [LOGN-1:0] old_address_4,
  output logic [LOGN-1:0] old_address_5,
  output logic [LOGN-1:0] old_address_6,
  output logic [LOGN-1:0] old_address_7,
  output logic [LOGN-2:0] twiddle_idx_0,
  output logic [LOGN-2:0] twiddle_idx_1,
  output logic [LOGN-2:0] twiddle_idx_2,
  output logic [LOGN-2:0] twiddle_idx_3,
  output logic [3:0]      stage,
  output logic            last
);

  import ntt_pkg::*;

  // Beat counter width: k = LANES*g + lane spans LOGN-1 bits with 4 lanes
  localparam int             c_gw     = LOGN - 3;
  localparam logic [c_gw-1:0] c_last_g = {c_gw{1'b1}};
  localparam logic [3:0]     c_last_s = 4'(LOGN - 1);

  state_t          r_state;
  state_t          w_state_next;

  logic [c_gw-1:0] r_g;
  logic [3:0]      r_s;
  logic            r_inv;
  logic            r_valid;
  logic            r_last;
  logic [3:0]      r_stage;
  logic [LOGN-1:0] r_addr [2*LANES];
  logic [LOGN-2:0] r_tw   [LANES];

  logic            w_hs;
  logic            w_start;
  logic            w_g_end;
  logic            w_s_final;
  logic            w_final_hs;
  logic            w_load;
  logic            w_ld_inv;
  logic [c_gw-1:0] w_ld_g;
  logic [3:0]      w_ld_s;
  logic            w_ld_last;
  logic [LOGN-1:0] w_top [LANES];
  logic [LOGN-1:0] w_bot [LANES];
  logic [LOGN-2:0] w_tw  [LANES];

  // Handshake and end-of-walk qualifiers
  always_comb begin
    w_hs       = r_valid & out_ready;
    w_start    = (r_state == IDLE) & start;
    w_g_end    = (r_g == c_last_g);
    w_s_final  = r_inv ? (r_s == 4'd0) : (r_s == c_last_s);
    w_final_hs = (r_state == RUN) & w_hs & w_g_end & w_s_final;
    w_load     = w_start | ((r_state == RUN) & w_hs & ~w_final_hs);
  end

  // Coordinates of the beat to load next: first beat on start, else successor
  always_comb begin
    w_ld_inv = w_start ? inverse : r_inv;
    w_ld_g   = r_g + 1'b1;
    w_ld_s   = r_s;
    if (w_start) begin
      w_ld_g = '0;
      w_ld_s = inverse ? c_last_s : 4'd0;
    end else if (w_g_end) begin
      w_ld_g = '0;
      w_ld_s = r_inv ? (r_s - 4'd1) : (r_s + 4'd1);
    end
    w_ld_last = (w_ld_g == c_last_g) &
                (w_ld_s == (w_ld_inv ? 4'd0 : c_last_s));
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      ntt_lane_addr u_lane (
        .k       ({w_ld_g, 2'(i)}),
        .s       (w_ld_s),
        .top     (w_top[i]),
        .bottom  (w_bot[i]),
        .twiddle (w_tw[i])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: start launches a walk, final handshake ends it, DONE lasts one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)      w_state_next = RUN;
      RUN:     if (w_final_hs) w_state_next = DONE;
      DONE:                    w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // Beat registers: load the next beat on start or any non-final handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g     <= '0;
      r_s     <= '0;
      r_inv   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_stage <= '0;
      for (int i = 0; i < 2*LANES; i++) r_addr[i] <= '0;
      for (int i = 0; i < LANES; i++)   r_tw[i]   <= '0;
    end else begin
      if (w_start) r_inv <= inverse;
      if (w_load) begin
        r_g     <= w_ld_g;
        r_s     <= w_ld_s;
        r_valid <= 1'b1;
        r_last  <= w_ld_last;
        r_stage <= w_ld_s;
        for (int i = 0; i < LANES; i++) begin
          r_addr[2*i]   <= w_top[i];
          r_addr[2*i+1] <= w_bot[i];
          r_tw[i]       <= w_tw[i];
        end
      end else if (w_final_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out_valid     = r_valid;
  assign last          = r_last;
  assign stage         = r_stage;
  assign old_address_0 = r_addr[0];
  assign old_address_1 = r_addr[1];
  assign old_address_2 = r_addr[2];
  assign old_address_3 = r_addr[3];
  assign old_address_4 = r_addr[4];
  assign old_address_5 = r_addr[5];
  assign old_address_6 = r_addr[6];
  assign old_address_7 = r_addr[7];
  assign twiddle_idx_0 = r_tw[0];
  assign twiddle_idx_1 = r_tw[1];
  assign twiddle_idx_2 = r_tw[2];
  assign twiddle_idx_3 = r_tw[3];

endmodule
`default_nettype wire

// File: tb/tb_ntt_address_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_address_generator
//  Description : Directed self-checking bench for ntt_address_generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_address_generator;

  logic       clk = 1'b0;
  logic       rst, start, inverse, out_ready;
  logic       busy, done, out_valid, last;
  logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [8:0] t0, t1, t2, t3;
  logic [3:0] stage;
  logic [9:0] addr [8];
  logic [8:0] tw   [4];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int exp_idx  = 0;
  int cyc      = 0;
  logic exp_inv = 1'b0;

  always #5 clk = ~clk;

  ntt_address_generator #(.LOGN(10), .LANES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .old_address_0(a0), .old_address_1(a1), .old_address_2(a2), .old_address_3(a3),
    .old_address_4(a4), .old_address_5(a5), .old_address_6(a6), .old_address_7(a7),
    .twiddle_idx_0(t0), .twiddle_idx_1(t1), .twiddle_idx_2(t2), .twiddle_idx_3(t3),
    .stage(stage), .last(last)
  );

  always_comb begin
    addr[0] = a0; addr[1] = a1; addr[2] = a2; addr[3] = a3;
    addr[4] = a4; addr[5] = a5; addr[6] = a6; addr[7] = a7;
    tw[0] = t0; tw[1] = t1; tw[2] = t2; tw[3] = t3;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Top address: k with a zero bit inserted at position s
  function automatic logic [9:0] model_top(input int k, input int s);
    logic [9:0] r;
    logic [31:0] kb;
    r  = '0;
    kb = k;
    for (int b = 0; b < 10; b++) begin
      if (b < s)      r[b] = kb[b];
      else if (b > s) r[b] = kb[b-1];
    end
    return r;
  endfunction

  // Observe the beat offered at the coming edge, then advance to the next negedge
  task automatic step();
    if (out_valid && out_ready) begin
      int g;
      int st;
      g  = exp_idx % 128;
      st = exp_inv ? 9 - exp_idx / 128 : exp_idx / 128;
      check_value("beat_stage", stage, st);
      check_value("beat_last", last, exp_idx == 1279);
      for (int i = 0; i < 4; i++) begin
        int k;
        logic [9:0] t;
        k = 4 * g + i;
        t = model_top(k, st);
        check_value("beat_top", addr[2*i], t);
        check_value("beat_bottom", addr[2*i+1], t | (10'd1 << st));
        check_value("beat_twiddle", tw[i], (k % (1 << st)) << (9 - st));
      end
      exp_idx++;
      hs_count++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic begin_run(input logic inv);
    inverse   = inv;
    exp_inv   = inv;
    start     = 1'b1;
    out_ready = 1'b1;
    exp_idx   = 0;
    hs_count  = 0;
    cyc       = 0;
    step();
    start     = 1'b0;
  endtask

  task automatic run_until(input int n);
    int guard;
    guard = 0;
    while (hs_count < n && guard < 4000) begin
      step();
      guard++;
    end
    check_value("reach_beat", hs_count, n);
  endtask

  task automatic run_to_done();
    int guard;
    guard = 0;
    while (!done && guard < 4000) begin
      step();
      guard++;
    end
    check_value("done_seen", done, 1);
  endtask

  task automatic check_beat8(input string tag, input int v0, v1, v2, v3, v4, v5, v6, v7);
    int e [8];
    e = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++) check_value(tag, addr[i], e[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inverse = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();

    // Reset values
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_valid", out_valid, 0);
    check_value("rst_last", last, 0);
    check_value("rst_stage", stage, 0);
    check_value("rst_addr0", a0, 0);
    check_value("rst_addr7", a7, 0);
    check_value("rst_tw3", t3, 0);

    // Forward walk, ready held high
    begin_run(1'b0);
    check_value("fwd0_valid", out_valid, 1);
    check_value("fwd0_busy", busy, 1);
    check_value("fwd0_stage", stage, 0);
    check_value("fwd0_last", last, 0);
    check_beat8("fwd0_addr", 0, 1, 2, 3, 4, 5, 6, 7);
    for (int i = 0; i < 4; i++) check_value("fwd0_tw", tw[i], 0);

    run_until(384);
    check_value("s3_stage", stage, 3);
    check_beat8("s3_addr", 0, 8, 1, 9, 2, 10, 3, 11);
    check_value("s3_tw0", t0, 0);
    check_value("s3_tw1", t1, 64);
    check_value("s3_tw2", t2, 128);
    check_value("s3_tw3", t3, 192);

    run_until(1279);
    check_value("fin_cycle", cyc, 1280);
    check_value("fin_stage", stage, 9);
    check_value("fin_last", last, 1);
    check_value("fin_done_early", done, 0);
    check_beat8("fin_addr", 508, 1020, 509, 1021, 510, 1022, 511, 1023);
    for (int i = 0; i < 4; i++) check_value("fin_tw", tw[i], 508 + i);
    step();
    check_value("done_cycle", cyc, 1281);
    check_value("done_pulse", done, 1);
    check_value("done_busy", busy, 0);
    check_value("done_valid", out_valid, 0);
    check_value("done_hs_total", hs_count, 1280);
    step();
    check_value("done_one_cycle", done, 0);

    // Backpressure at g=10, plus a start pulse during RUN
    begin_run(1'b0);
    run_until(10);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("bp_valid", out_valid, 1);
      check_value("bp_stage", stage, 0);
      check_beat8("bp_addr", 80, 81, 82, 83, 84, 85, 86, 87);
    end
    out_ready = 1'b1;
    step();
    check_beat8("bp_next", 88, 89, 90, 91, 92, 93, 94, 95);
    run_until(500);
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done();
    check_value("bp_cycle", cyc, 1286);
    check_value("bp_hs_total", hs_count, 1280);
    step();

    // Inverse walk, then reset mid-run
    begin_run(1'b1);
    inverse = 1'b0;
    check_value("inv0_stage", stage, 9);
    check_beat8("inv0_addr", 0, 512, 1, 513, 2, 514, 3, 515);
    run_until(128);
    check_value("inv129_stage", stage, 8);
    check_value("inv129_addr1", a1, 256);
    run_until(300);
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check_value("mrst_busy", busy, 0);
    check_value("mrst_done", done, 0);
    check_value("mrst_valid", out_valid, 0);
    check_value("mrst_stage", stage, 0);
    check_value("mrst_addr1", a1, 0);
    step();
    check_value("mrst_no_done", done, 0);
    rst = 1'b0;
    step();
    check_value("mrst_idle_done", done, 0);
    begin_run(1'b0);
    check_value("restart_stage", stage, 0);
    check_value("restart_valid", out_valid, 1);
    check_beat8("restart_addr", 0, 1, 2, 3, 4, 5, 6, 7);
    run_to_done();
    check_value("restart_hs_total", hs_count, 1280);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
